row_feeder: RTL

Producer-side counterpart of the per-row renderer. It accepts one traced wall result per screen row (side, size, texu) from the wall tracer over a valid/ready handshake and double-buffers it. It precomputes the texture-v step with an iterative divider, then presents a stable row descriptor plus a per-pixel `texv` to the renderer for the whole visible line. It sits between the tracer and the row renderer, clocked at pixel rate.

---
 rtl/row_pkg.sv | 26 ++
 rtl/recip_div.sv | 60 ++++++
 rtl/row_feeder.sv | 94 +++++++++
 3 files changed

// File: rtl/row_pkg.sv
// Shared constants, FSM encoding and row descriptor for the row feeder.
// acc_load gives the accumulator value at hpos 0: 32.0 - HALF*step.
package row_pkg;
    localparam int H_VIEW = 640;
    localparam int HALF   = H_VIEW / 2;
    localparam int SIZE_W = 11;
    localparam int FRAC   = 10;
    localparam int TEX_W  = 6;
    localparam int STEP_W = 16;
    localparam int ACC_W  = 26;

    typedef enum logic [1:0] {EMPTY, DIV, FULL} state_t;

    typedef struct packed {
        logic              side;
        logic [SIZE_W-1:0] size;
        logic [TEX_W-1:0]  texu;
    } row_t;

    // Centre the line on texv=32 so the wall column is symmetric about HALF.
    function automatic logic signed [ACC_W-1:0] acc_load(input logic [STEP_W-1:0] step);
        logic signed [ACC_W-1:0] s;
        s = ACC_W'(step);
        return (ACC_W'(32) << FRAC) - s * ACC_W'(HALF);
    endfunction
endpackage

// File: rtl/recip_div.sv
// Restoring divider: quot = 2^(QW-1) / divisor, one quotient bit per cycle.
// A zero divisor never borrows, so it naturally yields all ones.
module recip_div
    import row_pkg::*;
#(
    parameter int DW = SIZE_W,
    parameter int QW = STEP_W
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          start,
    input  logic [DW-1:0] divisor,
    output logic [QW-1:0] quot,
    output logic          done
);
    localparam int CW = $clog2(QW);

    logic [DW-1:0] dvs;
    logic [DW-1:0] rem;
    logic [CW-1:0] cnt;
    logic          busy;
    logic [DW:0]   trial;
    logic [DW-1:0] diff;
    logic          borrow;

    // The dividend has only its MSB set, so only the first shift brings in a 1.
    always_comb begin
        trial  = {rem, (cnt == '0)};
        borrow = (trial < {1'b0, dvs});
        diff   = trial[DW-1:0] - dvs;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dvs  <= '0;
            rem  <= '0;
            cnt  <= '0;
            busy <= 1'b0;
            quot <= '0;
            done <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                dvs  <= divisor;
                rem  <= '0;
                quot <= '0;
                cnt  <= '0;
                busy <= 1'b1;
            end else if (busy) begin
                rem  <= borrow ? trial[DW-1:0] : diff;
                quot <= {quot[QW-2:0], ~borrow};
                cnt  <= cnt + 1'b1;
                if (cnt == CW'(QW - 1)) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end
endmodule

// File: rtl/row_feeder.sv
// Double-buffers one traced wall result per row, precomputes the texv step,
// and streams a stable row descriptor plus per-pixel texv to the renderer.
module row_feeder
    import row_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_side,
    input  logic [SIZE_W-1:0] in_size,
    input  logic [TEX_W-1:0]  in_texu,
    input  logic              line_start,
    input  logic              visible,
    output logic              side,
    output logic [SIZE_W-1:0] size,
    output logic [TEX_W-1:0]  texu,
    output logic [TEX_W-1:0]  texv,
    output logic              underrun
);
    state_t                   state, nstate;
    row_t                     pend, act;
    logic [STEP_W-1:0]        step, act_step;
    logic signed [ACC_W-1:0]  acc, step_ext;
    logic                     accept, take, div_done;

    assign in_ready = (state == EMPTY);
    assign accept   = in_valid && in_ready;
    assign take     = line_start && (state == FULL);
    assign step_ext = {{(ACC_W-STEP_W){1'b0}}, act_step};

    // The divider holds its quotient until the next accept, which can only
    // happen after the pending row has been promoted, so it doubles as the
    // pending step register.
    recip_div #(.DW(SIZE_W), .QW(STEP_W)) u_div (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (accept),
        .divisor (in_size),
        .quot    (step),
        .done    (div_done)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= EMPTY;
        else          state <= nstate;
    end

    always_comb begin
        nstate = state;
        case (state)
            EMPTY:   if (accept)     nstate = DIV;
            DIV:     if (div_done)   nstate = FULL;
            FULL:    if (line_start) nstate = EMPTY;
            default: nstate = EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pend     <= '0;
            act      <= '0;
            act_step <= '0;
            acc      <= '0;
            underrun <= 1'b0;
        end else begin
            if (accept) pend <= {in_side, in_size, in_texu};
            if (line_start) begin
                underrun <= !take;
                if (take) begin
                    act      <= pend;
                    act_step <= step;
                    acc      <= acc_load(step);
                end else begin
                    // Repeat the previous row exactly rather than show a torn one.
                    acc      <= acc_load(act_step);
                end
            end else begin
                underrun <= 1'b0;
                if (visible) acc <= acc + step_ext;
            end
        end
    end

    always_comb begin
        texv = acc[FRAC+TEX_W-1:FRAC];
        if (acc[ACC_W-1])                   texv = '0;
        else if (|acc[ACC_W-2:FRAC+TEX_W])  texv = '1;
    end

    assign side = act.side;
    assign size = act.size;
    assign texu = act.texu;
endmodule
